// File: rtl/audio_ds_decoder.sv
// Second-order CIC decoder for the left/right 1-bit delta-sigma audio streams.
// Define AUDIO_DS_DECODER_OVERRUN_EN to add the sticky overrun flag and its clear input.
module audio_ds_decoder #(
  parameter int unsigned SAMPLE_WIDTH    = 16,
  parameter int unsigned LOG2_DECIMATION = 8
) (
  input  logic                    i_sys_clock,
  input  logic                    i_reset_,
  input  logic                    i_enable,
  input  logic                    i_audio_left,
  input  logic                    i_audio_right,
  output logic [SAMPLE_WIDTH-1:0] o_sample_left,
  output logic [SAMPLE_WIDTH-1:0] o_sample_right,
  output logic                    o_sample_valid,
  input  logic                    i_sample_ready
`ifdef AUDIO_DS_DECODER_OVERRUN_EN
  ,
  output logic                    o_overrun,
  input  logic                    i_overrun_clear
`endif
);

  localparam int unsigned ACC_W = 2 * LOG2_DECIMATION + 1;
  localparam int unsigned RAW_W = 2 * LOG2_DECIMATION;

  logic [LOG2_DECIMATION-1:0]   r_phase;
  logic [1:0]                   r_warm;
  logic [1:0][ACC_W-1:0]        r_int1;
  logic [1:0][ACC_W-1:0]        r_int2;
  logic [1:0][ACC_W-1:0]        r_dly1;
  logic [1:0][ACC_W-1:0]        r_dly2;
  logic [1:0][SAMPLE_WIDTH-1:0] r_sample;
  logic                         r_valid;

  logic [1:0]                   w_bit;
  logic                         w_tick;
  logic                         w_load;
  logic [1:0][ACC_W-1:0]        w_int1_d;
  logic [1:0][ACC_W-1:0]        w_int2_d;
  logic [1:0][ACC_W-1:0]        w_comb1;
  logic [1:0][ACC_W-1:0]        w_comb2;
  logic [1:0][RAW_W-1:0]        w_clamp;
  logic [1:0][SAMPLE_WIDTH-1:0] w_sample;

  // Index 0 is the left channel, index 1 the right.
  assign w_bit  = {i_audio_right, i_audio_left};
  assign w_tick = i_enable && (r_phase == '1);
  assign w_load = w_tick && (r_warm == 2'd2);

  // The tick cycle's own bit is folded in by feeding the combs from the next-state integrators.
  always_comb begin
    for (int ch = 0; ch < 2; ch++) begin
      w_int1_d[ch] = r_int1[ch] + ACC_W'(w_bit[ch]);
      w_int2_d[ch] = r_int2[ch] + w_int1_d[ch];
      w_comb1[ch]  = w_int2_d[ch] - r_dly1[ch];
      w_comb2[ch]  = w_comb1[ch] - r_dly2[ch];
      w_clamp[ch]  = w_comb2[ch][RAW_W] ? '1 : w_comb2[ch][RAW_W-1:0];
      w_sample[ch] = {~w_clamp[ch][RAW_W-1], w_clamp[ch][RAW_W-2 -: SAMPLE_WIDTH-1]};
    end
  end

  always_ff @(posedge i_sys_clock or negedge i_reset_) begin
    if (!i_reset_) begin
      r_phase  <= '0;
      r_warm   <= '0;
      r_int1   <= '0;
      r_int2   <= '0;
      r_dly1   <= '0;
      r_dly2   <= '0;
      r_sample <= '0;
      r_valid  <= 1'b0;
    end else if (!i_enable) begin
      // Sample data is deliberately held across a disable.
      r_phase <= '0;
      r_warm  <= '0;
      r_int1  <= '0;
      r_int2  <= '0;
      r_dly1  <= '0;
      r_dly2  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_phase <= r_phase + 1'b1;
      r_int1  <= w_int1_d;
      r_int2  <= w_int2_d;
      if (w_tick) begin
        r_dly1 <= w_int2_d;
        r_dly2 <= w_comb1;
        if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      end
      if (w_load) begin
        r_sample <= w_sample;
        r_valid  <= 1'b1;
      end else if (r_valid && i_sample_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign o_sample_left  = r_sample[0];
  assign o_sample_right = r_sample[1];
  assign o_sample_valid = r_valid;

`ifdef AUDIO_DS_DECODER_OVERRUN_EN
  logic r_overrun;
  logic w_overrun_set;

  assign w_overrun_set = w_load && r_valid && !i_sample_ready;

  always_ff @(posedge i_sys_clock or negedge i_reset_) begin
    if (!i_reset_) begin
      r_overrun <= 1'b0;
    end else if (w_overrun_set) begin
      r_overrun <= 1'b1;
    end else if (i_overrun_clear) begin
      r_overrun <= 1'b0;
    end
  end

  assign o_overrun = r_overrun;
`endif

endmodule

// File: tb/tb_audio_ds_decoder.sv
// Bench for audio_ds_decoder: directed phases plus random bitstreams checked against a
// triangular-kernel convolution model of the decimator.
module tb_audio_ds_decoder;

  localparam int L  = 8;
  localparam int SW = 16;
  localparam int R  = 1 << L;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        en    = 1'b1;
  logic        bl    = 1'b0;
  logic        br    = 1'b0;
  logic        ready = 1'b1;
  logic        oclr  = 1'b0;
  logic [15:0] s_l;
  logic [15:0] s_r;
  logic        s_v;
`ifdef AUDIO_DS_DECODER_OVERRUN_EN
  logic        ovr;
`endif

  audio_ds_decoder #(
    .SAMPLE_WIDTH   (SW),
    .LOG2_DECIMATION(L)
  ) dut (
    .i_sys_clock   (clk),
    .i_reset_      (rst_n),
    .i_enable      (en),
    .i_audio_left  (bl),
    .i_audio_right (br),
    .o_sample_left (s_l),
    .o_sample_right(s_r),
    .o_sample_valid(s_v),
    .i_sample_ready(ready)
`ifdef AUDIO_DS_DECODER_OVERRUN_EN
    ,
    .o_overrun      (ovr),
    .i_overrun_clear(oclr)
`endif
  );

  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int          n      = 0;
  bit          hl[$];
  bit          hr[$];
  logic        m_v    = 1'b0;
  logic [15:0] m_l    = '0;
  logic [15:0] m_r    = '0;
  logic        m_o    = 1'b0;
  int          mode   = 0;   // 0 hold bits, 1 alternate, 2 random
  int          pl     = 50;
  int          pr     = 50;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sample = convolution of the last 2R-1 bits with the 1..R..1 triangle, clamped and centred.
  function automatic logic [15:0] pcm(input int ch);
    int raw;
    int w;
    int sz;
    int sv;
    bit b;
    raw = 0;
    sz  = hl.size();
    for (int j = 0; j < 2 * R - 1; j++) begin
      w = (j < R) ? j + 1 : 2 * R - 1 - j;
      if (j < sz) b = (ch == 0) ? hl[sz-1-j] : hr[sz-1-j];
      else        b = 1'b0;
      if (b) raw += w;
    end
    if (raw > R * R - 1) raw = R * R - 1;
    sv = (raw - R * R / 2) >>> (2 * L - SW);
    return sv[15:0];
  endfunction

  task automatic model_step();
    bit set;
    set = 1'b0;
    if (!rst_n) return;
    if (!en) begin
      n = 0;
      hl.delete();
      hr.delete();
      m_v = 1'b0;
    end else begin
      hl.push_back(bl);
      hr.push_back(br);
      if (hl.size() > 2 * R) begin
        void'(hl.pop_front());
        void'(hr.pop_front());
      end
      n++;
      if (n % R == 0 && n / R >= 3) begin
        set = m_v && !ready;
        m_v = 1'b1;
        m_l = pcm(0);
        m_r = pcm(1);
      end else if (m_v && ready) begin
        m_v = 1'b0;
      end
    end
    if (set) m_o = 1'b1;
    else if (oclr) m_o = 1'b0;
  endtask

  task automatic compare_all();
    check("valid", s_v, m_v);
    check("left", s_l, m_l);
    check("right", s_r, m_r);
`ifdef AUDIO_DS_DECODER_OVERRUN_EN
    check("overrun", ovr, m_o);
`endif
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    if (mode == 1) begin
      bl = ~bl;
      br = ~br;
    end else if (mode == 2) begin
      bl = ($urandom_range(0, 99) < pl);
      br = ($urandom_range(0, 99) < pr);
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    n = 0;
    hl.delete();
    hr.delete();
    m_v = 1'b0;
    m_l = '0;
    m_r = '0;
    m_o = 1'b0;
    check("rst_valid", s_v, 1'b0);
    check("rst_left", s_l, 16'h0000);
    check("rst_right", s_r, 16'h0000);
`ifdef AUDIO_DS_DECODER_OVERRUN_EN
    check("rst_overrun", ovr, 1'b0);
`endif
    cycle();
    cycle();
  endtask

  task automatic run_to_first_valid(input string tag);
    int first;
    first = -1;
    for (int i = 1; i <= 4 * R; i++) begin
      cycle();
      if (s_v === 1'b1) begin
        first = i;
        break;
      end
    end
    check(tag, first, 3 * R);
  endtask

  initial begin
    int prev;
    int edge_no;

    // Constant ones on both channels, ready held high.
    mode = 0; bl = 1'b1; br = 1'b1; ready = 1'b1; en = 1'b1;
    apply_reset();
    rst_n = 1'b1;
    run_to_first_valid("ones_first_valid");
    check("ones_first_left", s_l, 16'h7FFF);
    check("ones_first_right", s_r, 16'h7FFF);
    prev    = 3 * R;
    edge_no = 3 * R;
    for (int i = 0; i < 3 * R; i++) begin
      cycle();
      edge_no++;
      if (s_v) begin
        check("ones_left", s_l, 16'h7FFF);
        check("ones_right", s_r, 16'h7FFF);
        check("ones_spacing", edge_no - prev, R);
        prev = edge_no;
      end
    end

    // Left constant 0, right constant 1.
    bl = 1'b0; br = 1'b1;
    apply_reset();
    rst_n = 1'b1;
    run_to_first_valid("split_first_valid");
    for (int i = 0; i < 2 * R + 1; i++) begin
      if (s_v) begin
        check("split_left", s_l, 16'h8000);
        check("split_right", s_r, 16'h7FFF);
      end
      cycle();
    end

    // Alternating 1,0 on both channels.
    bl = 1'b1; br = 1'b1; mode = 1;
    apply_reset();
    rst_n = 1'b1;
    run_to_first_valid("alt_first_valid");
    for (int i = 0; i < 3 * R; i++) begin
      if (s_v) begin
        check("alt_left", s_l, 16'h0000);
        check("alt_right", s_r, 16'h0000);
      end
      cycle();
    end

    // Back-pressure for 600 cycles, then clear the overrun flag.
    mode = 2;
    ready = 1'b0;
    for (int i = 0; i < R + 2 && !s_v; i++) cycle();
    check("bp_valid_start", s_v, 1'b1);
    for (int i = 0; i < 600; i++) cycle();
    check("bp_valid_held", s_v, 1'b1);
`ifdef AUDIO_DS_DECODER_OVERRUN_EN
    check("bp_overrun_set", ovr, 1'b1);
`endif
    oclr = 1'b1; ready = 1'b1;
    cycle();
    oclr = 1'b0;
`ifdef AUDIO_DS_DECODER_OVERRUN_EN
    check("bp_overrun_clear", ovr, 1'b0);
`endif

    // Reset while an overrun is being recorded.
    ready = 1'b0;
    for (int i = 0; i < 2 * R + 5; i++) cycle();
    apply_reset();
    ready = 1'b1;
    rst_n = 1'b1;
    run_to_first_valid("rst_ovr_first_valid");

    // Reset during warm-up.
    for (int i = 0; i < R + 37; i++) cycle();
    apply_reset();
    rst_n = 1'b1;
    run_to_first_valid("rst_warm_first_valid");

    // Enable dropped for 10 cycles while a sample is held.
    ready = 1'b0;
    for (int i = 0; i < R + 2 && !s_v; i++) cycle();
    check("en_valid_before", s_v, 1'b1);
    en = 1'b0;
    cycle();
    check("en_valid_drop", s_v, 1'b0);
    for (int i = 0; i < 9; i++) cycle();
    en = 1'b1;
    ready = 1'b1;
    run_to_first_valid("en_first_valid");

    // Random densities and random back-pressure.
    for (int blk = 0; blk < 6; blk++) begin
      pl = $urandom_range(0, 100);
      pr = $urandom_range(0, 100);
      for (int i = 0; i < 512; i++) begin
        ready = ($urandom_range(0, 3) != 0);
        oclr  = ($urandom_range(0, 15) == 0);
        cycle();
      end
    end
    oclr = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/audio_ds_decoder.md
# audio_ds_decoder

Receive-side counterpart of the audioX 1-bit delta-sigma audio output. Samples the left/right 1-bit streams on sys_clock and recovers signed PCM samples with a per-channel second-order CIC decimator. Results are presented on a valid/ready sample port. Used in loopback self-test builds and as the bench reference model for the audio output path.

## Interface
- SAMPLE_WIDTH, 16, output sample width in bits, signed.
- LOG2_DECIMATION, 8, log2 of the decimation ratio R. Constraint: 2*LOG2_DECIMATION >= SAMPLE_WIDTH.

- sys_clock  in  1  single clock for all logic.
- reset_  in  1  asynchronous, active-low reset.
- enable  in  1  run enable, normally driven by pll_locked. Low holds the decoder in a cleared state.
- audio_left  in  1  left-channel bitstream, synchronous to sys_clock.
- audio_right  in  1  right-channel bitstream, synchronous to sys_clock.
- sample_left  out  SAMPLE_WIDTH  decoded left sample, two's complement.
- sample_right  out  SAMPLE_WIDTH  decoded right sample, two's complement.
- sample_valid  out  1  sample pair available.
- sample_ready  in  1  consumer accepts the pair when valid and ready are both high.
- overrun  out  1  sticky overrun flag. Present only with AUDIO_DS_DECODER_OVERRUN_EN.
- overrun_clear  in  1  clears overrun. Present only with AUDIO_DS_DECODER_OVERRUN_EN.

## Operation
- Input mapping: a bit value of 1 adds 1 and a bit value of 0 adds 0. No input synchronizers are used; the streams are in the sys_clock domain.
- Phase counter: LOG2_DECIMATION bits, increments every enabled cycle and wraps R-1 -> 0. The cycle with count R-1 is a tick; that cycle's input bit is included in the tick.
- Integrators: two cascaded integrators per channel, each 2*LOG2_DECIMATION+1 bits wide with modular arithmetic. They update every enabled cycle.
- Combs: on each tick, two cascaded comb stages run at the decimated rate, using one delay register per stage.
- The raw comb output ranges over 0..R^2.
- Scaling:
  - Clamp the raw value to R^2-1.
  - Invert bit 2*LOG2_DECIMATION-1 to obtain a signed 2*LOG2_DECIMATION-bit value.
  - Arithmetic right shift by 2*LOG2_DECIMATION-SAMPLE_WIDTH.
  - With the defaults: all-1 input gives 0x7FFF, all-0 gives 0x8000, and an alternating 1010 pattern gives 0x0000.
- Warm-up: a 2-bit warm-up counter discards the results of the first two ticks after reset or after enable rises. The third and all later ticks produce samples.
- Output register: holds one sample pair.
  - sample_valid rises when a non-discarded tick loads the register.
  - sample_valid falls on the cycle after acceptance, unless a new tick loads the register in that same cycle.
- Overrun: a tick that arrives while sample_valid=1 and sample_ready=0 overwrites the held pair, and sample_valid stays 1. With the macro enabled, the overrun flag is also set.
- Simultaneous acceptance and tick: the new pair loads, sample_valid stays 1, and no overrun is recorded.
- enable low: on the next clock, the following are all cleared to 0 synchronously:
  - phase counter
  - integrators
  - comb delays
  - warm-up counter
  - sample_valid
  
  Sample outputs hold their last values. The overrun flag is unaffected.
- Asserting reset_ mid-operation takes effect immediately and clears all state, with no partial sample emitted.

## Timing
- Reset values:
  - sample_left = 0, sample_right = 0
  - sample_valid = 0
  - overrun = 0
  - all internal state = 0
- Latency: sample_valid and the sample data change on the first sys_clock edge after the tick cycle, i.e. 1 cycle after the tick.
- After reset_ deassertion with enable high, the first tick is at enabled cycle R. The first sample_valid occurs at cycle 3R+1.
- Acceptance occurs on a rising edge where sample_valid and sample_ready are both 1.
- sample_ready may be held high permanently. In that case sample_valid is a 1-cycle pulse every R cycles.
- sample_left and sample_right are stable whenever sample_valid=1 and no tick occurs.
- overrun_clear and a set event in the same cycle: set wins.

## Configuration
- AUDIO_DS_DECODER_OVERRUN_EN defined:
  - The overrun and overrun_clear ports exist.
  - overrun goes high 1 cycle after the overwriting tick and stays high until overrun_clear.
- Not defined:
  - Both ports are absent.
  - Overwrite behaviour is unchanged and silent.

## Test plan
- Constant 1 on both channels, sample_ready=1, defaults: first sample_valid at cycle 769 after reset release, then both samples read 0x7FFF on every pulse at 256-cycle spacing.
- Constant 0 on left and constant 1 on right: left reads 0x8000 and right reads 0x7FFF from the first valid sample onward.
- Alternating 1,0 on both channels: every valid sample reads exactly 0x0000.
- sample_ready=0 for 600 cycles after the first valid: sample_valid stays 1 and the data is replaced at each tick. With the macro, overrun=1 one cycle after the first overwriting tick. Pulsing overrun_clear returns overrun to 0.
- Deassert enable mid-stream for 10 cycles: sample_valid drops 1 cycle later. After enable returns high, the next sample_valid occurs 3R+1 cycles later.
- Assert reset_ low during the warm-up period and again during an overrun: all outputs read 0 immediately, and sequencing restarts exactly as after the initial reset.
